// File: rtl/pic_ctrl_core_pkg.sv
// Shared types and constants for the 8259-style interrupt control core:
// init/ack state encodings, write-type decode and OCW2 command codes.
package pic_ctrl_core_pkg;

   typedef enum logic [2:0] {
      S_UNINIT,
      S_W_ICW2,
      S_W_ICW3,
      S_W_ICW4,
      S_READY
   } init_state_t;

   typedef enum logic [1:0] {
      A_IDLE,
      A_P1,
      A_WAIT,
      A_P2
   } ack_state_t;

   typedef enum logic [2:0] {
      WT_NONE,
      WT_ICW1,
      WT_ICW2,
      WT_ICW3,
      WT_ICW4,
      WT_OCW1,
      WT_OCW2,
      WT_OCW3
   } wr_type_t;

   // OCW2 {R, SL, EOI} command field
   localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // ICW1 is accepted in any state; OCWs only once initialisation is complete.
   function automatic wr_type_t decode_wr(input init_state_t st, input logic a0,
                                          input logic [7:0] din);
      wr_type_t wt;
      wt = WT_NONE;
      if (!a0) begin
         if (din[4])
            wt = WT_ICW1;
         else if (st == S_READY)
            wt = din[3] ? WT_OCW3 : WT_OCW2;
      end else begin
         case (st)
            S_W_ICW2: wt = WT_ICW2;
            S_W_ICW3: wt = WT_ICW3;
            S_W_ICW4: wt = WT_ICW4;
            S_READY:  wt = WT_OCW1;
            default:  wt = WT_NONE;
         endcase
      end
      return wt;
   endfunction

endpackage

// File: rtl/pic_ctrl_core_if.sv
// Bus, request and acknowledge signals between the host-side logic and the
// interrupt control core.
interface pic_ctrl_core_if #(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = 8
);
   logic               wr_stb;
   logic               a0;
   logic [7:0]         din;
   logic [NUM_IRQ-1:0] irq;
   logic               inta_n;
   logic               int_out;
   logic [VEC_W-1:0]   vec_out;
   logic               vec_oe;
   logic [7:0]         rd_data;
   logic [7:0]         icw3;
   logic               init_ok;

   modport master (
      output wr_stb, a0, din, irq, inta_n,
      input  int_out, vec_out, vec_oe, rd_data, icw3, init_ok
   );

   modport slave (
      input  wr_stb, a0, din, irq, inta_n,
      output int_out, vec_out, vec_oe, rd_data, icw3, init_ok
   );
endinterface

// File: rtl/pic_prio_resolver.sv
// Rotating priority resolver: rotates the request vector so the highest
// priority line sits at bit 0, finds the first set bit, then maps it back.
module pic_prio_resolver #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = 3
) (
   input  logic [NUM_IRQ-1:0] req,
   input  logic [ID_W-1:0]    lowest,
   output logic               valid,
   output logic [ID_W-1:0]    id,
   output logic [ID_W-1:0]    rank
);

   logic [NUM_IRQ-1:0] rot;

   // NUM_IRQ is a power of two, so ID_W-bit wraparound is the ring modulo.
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_rot
         logic [ID_W-1:0] src;
         assign src     = lowest + ID_W'(gi + 1);
         assign rot[gi] = req[src];
      end
   endgenerate

   always_comb begin
      valid = 1'b0;
      rank  = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid = 1'b1;
            rank  = ID_W'(i);
         end
      end
   end

   assign id = rank + lowest + ID_W'(1);

endmodule

// File: rtl/pic_ctrl_core.sv
// 8259-style interrupt control core: ICW/OCW decode, IRR/ISR/IMR, rotating
// fully-nested priority and the two-pulse INTA acknowledge sequence.
module pic_ctrl_core
   import pic_ctrl_core_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = 8
) (
   input logic            clk,
   input logic            rst,
   pic_ctrl_core_if.slave bus
);

   localparam int ID_W   = id_width(NUM_IRQ);
   localparam int BASE_W = VEC_W - ID_W;

   init_state_t        init_reg, init_next;
   ack_state_t         ack_reg, ack_next;
   logic [NUM_IRQ-1:0] imr_reg, imr_next;
   logic [NUM_IRQ-1:0] irr_reg, irr_next;
   logic [NUM_IRQ-1:0] isr_reg, isr_next;
   logic [NUM_IRQ-1:0] irq_prev_reg, irq_prev_next;
   logic [ID_W-1:0]    lowest_reg, lowest_next;
   logic [ID_W-1:0]    ack_id_reg, ack_id_next;
   logic [BASE_W-1:0]  base_reg, base_next;
   logic [7:0]         icw3_reg, icw3_next;
   logic [VEC_W-1:0]   vec_out_reg, vec_out_next;
   logic               ltim_reg, ltim_next;
   logic               sngl_reg, sngl_next;
   logic               ic4_reg, ic4_next;
   logic               aeoi_reg, aeoi_next;
   logic               rot_aeoi_reg, rot_aeoi_next;
   logic               ris_reg, ris_next;
   logic               spur_reg, spur_next;
   logic               inta_prev_reg, inta_prev_next;
   logic               int_out_reg, int_out_next;
   logic               vec_oe_reg, vec_oe_next;

   logic               cand_valid, isr_valid;
   logic [ID_W-1:0]    cand_id, cand_rank, isr_id, isr_rank;
   logic               outranks;
   wr_type_t           wt;
   logic               inta_fall, inta_rise;
   logic [2:0]         l_full;
   logic               l_ok;
   logic [ID_W-1:0]    l_id;
   logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_clr;

   pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_req_res (
      .req(irr_reg & ~imr_reg), .lowest(lowest_reg),
      .valid(cand_valid), .id(cand_id), .rank(cand_rank)
   );

   pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
      .req(isr_reg), .lowest(lowest_reg),
      .valid(isr_valid), .id(isr_id), .rank(isr_rank)
   );

   assign outranks  = cand_valid && (!isr_valid || (cand_rank < isr_rank));
   assign wt        = bus.wr_stb ? decode_wr(init_reg, bus.a0, bus.din) : WT_NONE;
   assign inta_fall = inta_prev_reg & ~bus.inta_n;
   assign inta_rise = ~inta_prev_reg & bus.inta_n;
   assign l_full    = bus.din[2:0];
   assign l_ok      = ((l_full >> ID_W) == 3'd0);
   assign l_id      = bus.din[ID_W-1:0];

   always_comb begin
      init_next      = init_reg;
      ack_next       = ack_reg;
      imr_next       = imr_reg;
      lowest_next    = lowest_reg;
      ack_id_next    = ack_id_reg;
      base_next      = base_reg;
      icw3_next      = icw3_reg;
      vec_out_next   = vec_out_reg;
      ltim_next      = ltim_reg;
      sngl_next      = sngl_reg;
      ic4_next       = ic4_reg;
      aeoi_next      = aeoi_reg;
      rot_aeoi_next  = rot_aeoi_reg;
      ris_next       = ris_reg;
      spur_next      = spur_reg;
      vec_oe_next    = vec_oe_reg;
      irq_prev_next  = bus.irq;
      inta_prev_next = bus.inta_n;
      isr_set        = '0;
      isr_clr        = '0;
      irr_clr        = '0;

      case (ack_reg)
         A_IDLE: begin
            if (inta_fall && init_reg == S_READY) begin
               ack_next = A_P1;
               if (cand_valid) begin
                  ack_id_next      = cand_id;
                  spur_next        = 1'b0;
                  isr_set[cand_id] = 1'b1;
                  irr_clr[cand_id] = 1'b1;
               end else begin
                  ack_id_next = ID_W'(NUM_IRQ - 1);
                  spur_next   = 1'b1;
               end
            end
         end
         A_P1: if (inta_rise) ack_next = A_WAIT;
         A_WAIT: begin
            if (inta_fall) begin
               ack_next     = A_P2;
               vec_out_next = {base_reg, ack_id_reg};
               vec_oe_next  = 1'b1;
            end
         end
         A_P2: begin
            if (inta_rise) begin
               ack_next    = A_IDLE;
               vec_oe_next = 1'b0;
               if (aeoi_reg && !spur_reg) begin
                  isr_clr[ack_id_reg] = 1'b1;
                  if (rot_aeoi_reg)
                     lowest_next = ack_id_reg;
               end
            end
         end
         default: ack_next = A_IDLE;
      endcase

      case (wt)
         WT_OCW1: imr_next = bus.din[NUM_IRQ-1:0];
         WT_OCW2: begin
            // Non-specific EOI works on the ISR as it stood before this cycle.
            case (bus.din[7:5])
               OCW2_NS_EOI: if (isr_valid) isr_clr[isr_id] = 1'b1;
               OCW2_SP_EOI: if (l_ok) isr_clr[l_id] = 1'b1;
               OCW2_ROT_NS_EOI: begin
                  if (isr_valid) begin
                     isr_clr[isr_id] = 1'b1;
                     lowest_next     = isr_id;
                  end
               end
               OCW2_ROT_SP_EOI: begin
                  if (l_ok) begin
                     isr_clr[l_id] = 1'b1;
                     lowest_next   = l_id;
                  end
               end
               OCW2_SET_PRIO:     if (l_ok) lowest_next = l_id;
               OCW2_ROT_AEOI_SET: rot_aeoi_next = 1'b1;
               OCW2_ROT_AEOI_CLR: rot_aeoi_next = 1'b0;
               default: ;
            endcase
         end
         WT_OCW3: if (bus.din[1]) ris_next = bus.din[0];
         WT_ICW2: begin
            base_next = BASE_W'(bus.din[7:ID_W]);
            init_next = !sngl_reg ? S_W_ICW3 : (ic4_reg ? S_W_ICW4 : S_READY);
         end
         WT_ICW3: begin
            icw3_next = bus.din;
            init_next = ic4_reg ? S_W_ICW4 : S_READY;
         end
         WT_ICW4: begin
            aeoi_next = bus.din[1];
            init_next = S_READY;
         end
         default: ;
      endcase

      // Edge mode: a fresh rising edge beats an acknowledge clear of the same bit.
      if (ltim_reg)
         irr_next = bus.irq;
      else
         irr_next = (irr_reg & ~irr_clr) | (bus.irq & ~irq_prev_reg);
      isr_next = (isr_reg & ~isr_clr) | isr_set;

      if (wt == WT_ICW1) begin
         init_next   = S_W_ICW2;
         ack_next    = A_IDLE;
         vec_oe_next = 1'b0;
         imr_next    = '0;
         isr_next    = '0;
         irr_next    = '0;
         lowest_next = ID_W'(NUM_IRQ - 1);
         aeoi_next   = 1'b0;
         ris_next    = 1'b0;
         ltim_next   = bus.din[3];
         sngl_next   = bus.din[1];
         ic4_next    = bus.din[0];
      end

      int_out_next = (init_next == S_READY) && (ack_next == A_IDLE) && outranks;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_reg      <= S_UNINIT;
         ack_reg       <= A_IDLE;
         imr_reg       <= '1;
         irr_reg       <= '0;
         isr_reg       <= '0;
         irq_prev_reg  <= '0;
         lowest_reg    <= ID_W'(NUM_IRQ - 1);
         ack_id_reg    <= '0;
         base_reg      <= '0;
         icw3_reg      <= '0;
         vec_out_reg   <= '0;
         ltim_reg      <= 1'b0;
         sngl_reg      <= 1'b0;
         ic4_reg       <= 1'b0;
         aeoi_reg      <= 1'b0;
         rot_aeoi_reg  <= 1'b0;
         ris_reg       <= 1'b0;
         spur_reg      <= 1'b0;
         inta_prev_reg <= 1'b1;
         int_out_reg   <= 1'b0;
         vec_oe_reg    <= 1'b0;
      end else begin
         init_reg      <= init_next;
         ack_reg       <= ack_next;
         imr_reg       <= imr_next;
         irr_reg       <= irr_next;
         isr_reg       <= isr_next;
         irq_prev_reg  <= irq_prev_next;
         lowest_reg    <= lowest_next;
         ack_id_reg    <= ack_id_next;
         base_reg      <= base_next;
         icw3_reg      <= icw3_next;
         vec_out_reg   <= vec_out_next;
         ltim_reg      <= ltim_next;
         sngl_reg      <= sngl_next;
         ic4_reg       <= ic4_next;
         aeoi_reg      <= aeoi_next;
         rot_aeoi_reg  <= rot_aeoi_next;
         ris_reg       <= ris_next;
         spur_reg      <= spur_next;
         inta_prev_reg <= inta_prev_next;
         int_out_reg   <= int_out_next;
         vec_oe_reg    <= vec_oe_next;
      end
   end

   assign bus.int_out = int_out_reg;
   assign bus.vec_out = vec_out_reg;
   assign bus.vec_oe  = vec_oe_reg;
   assign bus.icw3    = icw3_reg;
   assign bus.init_ok = (init_reg == S_READY);
   assign bus.rd_data = bus.a0 ? 8'(imr_reg) : (ris_reg ? 8'(isr_reg) : 8'(irr_reg));

endmodule

// File: tb/tb_pic_ctrl_core.sv
// Self-checking bench for pic_ctrl_core: table vectors, hand-written corner
// sequences and randomised trials against a ring-priority model.
module tb_pic_ctrl_core;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pic_ctrl_core_if #(.NUM_IRQ(8), .VEC_W(8)) bus ();

   pic_ctrl_core #(.NUM_IRQ(8), .VEC_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [2:0] lowest;
      logic [7:0] imr;
      logic [7:0] irqs;
      logic       exp_int;
      logic [7:0] exp_vec;
      logic [7:0] exp_isr;
   } vec_t;

   vec_t tbl [8];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic a, input logic [7:0] d);
      bus.wr_stb = 1'b1;
      bus.a0     = a;
      bus.din    = d;
      tick(1);
      bus.wr_stb = 1'b0;
   endtask

   task automatic rd(input logic a, output logic [7:0] v);
      bus.a0 = a;
      #1;
      v = bus.rd_data;
   endtask

   task automatic read_isr(output logic [7:0] v);
      wr(1'b0, 8'h0B);
      rd(1'b0, v);
   endtask

   task automatic init(input logic [7:0] icw1, input logic [7:0] icw4);
      wr(1'b0, icw1);
      wr(1'b1, 8'h40);
      wr(1'b1, icw4);
   endtask

   // Two INTA pulses; vector sampled while the second pulse is low.
   task automatic do_ack(output logic [7:0] v, output logic oe);
      bus.inta_n = 1'b0; tick(2);
      bus.inta_n = 1'b1; tick(2);
      bus.inta_n = 1'b0; tick(2);
      oe = bus.vec_oe;
      v  = bus.vec_out;
      bus.inta_n = 1'b1; tick(2);
   endtask

   // Model: highest priority is lowest+1, descending around the ring.
   function automatic int pick(input int lo, input logic [7:0] pend);
      for (int k = 1; k <= 8; k++)
         if (pend[(lo + k) % 8]) return (lo + k) % 8;
      return -1;
   endfunction

   initial begin
      logic [7:0] v, r;
      logic       oe;
      int         id, id2, lo;
      logic [7:0] imr, pat, pend;

      bus.wr_stb = 1'b0; bus.a0 = 1'b0; bus.din = 8'h00;
      bus.irq = 8'h00; bus.inta_n = 1'b1;

      tbl[0] = '{3'd7, 8'h00, 8'h28, 1'b1, 8'h43, 8'h08};
      tbl[1] = '{3'd4, 8'h00, 8'h44, 1'b1, 8'h46, 8'h40};
      tbl[2] = '{3'd2, 8'h00, 8'h09, 1'b1, 8'h43, 8'h08};
      tbl[3] = '{3'd3, 8'h10, 8'h13, 1'b1, 8'h40, 8'h01};
      tbl[4] = '{3'd0, 8'h00, 8'h81, 1'b1, 8'h47, 8'h80};
      tbl[5] = '{3'd7, 8'hFF, 8'h04, 1'b0, 8'h47, 8'h00};
      tbl[6] = '{3'd6, 8'h80, 8'h81, 1'b1, 8'h40, 8'h01};
      tbl[7] = '{3'd5, 8'h00, 8'h02, 1'b1, 8'h41, 8'h02};

      tick(3);
      chk("rst_int_out", 32'(bus.int_out), 32'd0);
      chk("rst_vec_out", 32'(bus.vec_out), 32'd0);
      chk("rst_vec_oe", 32'(bus.vec_oe), 32'd0);
      chk("rst_init_ok", 32'(bus.init_ok), 32'd0);
      chk("rst_icw3", 32'(bus.icw3), 32'd0);
      rd(1'b1, r); chk("rst_imr", 32'(r), 32'hFF);
      rd(1'b0, r); chk("rst_irr", 32'(r), 32'h00);
      rst = 1'b0;
      tick(1);

      // ICW3 path with SNGL=0
      wr(1'b0, 8'h11); wr(1'b1, 8'h40);
      chk("icw3_pending_init", 32'(bus.init_ok), 32'd0);
      wr(1'b1, 8'h5A); wr(1'b1, 8'h01);
      chk("icw3_init_ok", 32'(bus.init_ok), 32'd1);
      chk("icw3_value", 32'(bus.icw3), 32'h5A);
      $display("icw3 sequence: icw3=%h init_ok=%0d", bus.icw3, bus.init_ok);

      // Table-driven priority vectors
      for (int t = 0; t < 8; t++) begin
         bus.irq = 8'h00; tick(2);
         init(8'h13, 8'h01);
         wr(1'b1, tbl[t].imr);
         wr(1'b0, {5'b11000, tbl[t].lowest});
         bus.irq = tbl[t].irqs;
         tick(1);
         chk($sformatf("tbl%0d_int_early", t), 32'(bus.int_out), 32'd0);
         tick(2);
         chk($sformatf("tbl%0d_int", t), 32'(bus.int_out), 32'(tbl[t].exp_int));
         do_ack(v, oe);
         chk($sformatf("tbl%0d_oe", t), 32'(oe), 32'd1);
         chk($sformatf("tbl%0d_vec", t), 32'(v), 32'(tbl[t].exp_vec));
         chk($sformatf("tbl%0d_oe_off", t), 32'(bus.vec_oe), 32'd0);
         read_isr(r);
         chk($sformatf("tbl%0d_isr", t), 32'(r), 32'(tbl[t].exp_isr));
         $display("vector %0d: lowest=%0d imr=%h irq=%h vec=%h isr=%h", t, tbl[t].lowest, tbl[t].imr, tbl[t].irqs, v, r);
      end

      // Full nesting
      bus.irq = 8'h00; tick(2);
      init(8'h13, 8'h01); wr(1'b1, 8'h00);
      bus.irq = 8'h08; tick(3);
      do_ack(v, oe);
      chk("nest_vec1", 32'(v), 32'h43);
      bus.irq = 8'h28; tick(3);
      chk("nest_lower_blocked", 32'(bus.int_out), 32'd0);
      bus.irq = 8'h2A; tick(3);
      chk("nest_higher_int", 32'(bus.int_out), 32'd1);
      do_ack(v, oe);
      chk("nest_vec2", 32'(v), 32'h41);
      read_isr(r); chk("nest_isr_0a", 32'(r), 32'h0A);
      wr(1'b0, 8'h20);
      rd(1'b0, r); chk("nest_nseoi_isr", 32'(r), 32'h08);
      $display("nesting: isr after eoi=%h", r);

      // Specific rotate then rotate-on-NS-EOI
      bus.irq = 8'h00; tick(2);
      init(8'h13, 8'h01); wr(1'b1, 8'h00); wr(1'b0, 8'hC4);
      bus.irq = 8'h44; tick(3);
      do_ack(v, oe);
      chk("rot_vec6", 32'(v), 32'h46);
      wr(1'b0, 8'hA0);
      read_isr(r); chk("rot_isr_clear", 32'(r), 32'h00);
      bus.irq = 8'hC4; tick(3);
      do_ack(v, oe);
      chk("rot_lowest6_vec7", 32'(v), 32'h47);
      $display("rotation: vec after lowest=6 is %h", v);

      // AEOI with rotation
      bus.irq = 8'h00; tick(2);
      init(8'h13, 8'h03); wr(1'b1, 8'h00); wr(1'b0, 8'h80);
      bus.irq = 8'h01; tick(3);
      do_ack(v, oe);
      chk("aeoi_vec0", 32'(v), 32'h40);
      read_isr(r); chk("aeoi_isr_auto_clear", 32'(r), 32'h00);
      bus.irq = 8'h00; tick(2);
      bus.irq = 8'h81; tick(3);
      do_ack(v, oe);
      chk("aeoi_rot_lowest0", 32'(v), 32'h47);
      $display("aeoi: second vec=%h", v);

      // Level-triggered request held across an AEOI acknowledge
      bus.irq = 8'h00; tick(2);
      init(8'h1B, 8'h03); wr(1'b1, 8'h00);
      bus.irq = 8'h01; tick(3);
      chk("level_int", 32'(bus.int_out), 32'd1);
      do_ack(v, oe);
      chk("level_vec", 32'(v), 32'h40);
      tick(1);
      chk("level_reassert", 32'(bus.int_out), 32'd1);
      $display("level: int_out after ack=%0d", bus.int_out);

      // Spurious acknowledge with everything masked
      bus.irq = 8'h00; tick(2);
      init(8'h13, 8'h01); wr(1'b1, 8'hFF);
      bus.irq = 8'h10; tick(3);
      chk("spur_no_int", 32'(bus.int_out), 32'd0);
      do_ack(v, oe);
      chk("spur_vec", 32'(v), 32'h47);
      read_isr(r); chk("spur_isr", 32'(r), 32'h00);
      wr(1'b0, 8'h0A);
      rd(1'b0, r); chk("spur_irr", 32'(r), 32'h10);
      $display("spurious: vec=%h irr=%h", v, r);

      // ICW1 between the two INTA pulses aborts the sequence
      bus.irq = 8'h00; tick(2);
      init(8'h13, 8'h01); wr(1'b1, 8'h00);
      bus.irq = 8'h04; tick(3);
      bus.inta_n = 1'b0; tick(2);
      bus.inta_n = 1'b1; tick(2);
      wr(1'b0, 8'h13);
      bus.inta_n = 1'b0; tick(2);
      chk("abort_vec_oe", 32'(bus.vec_oe), 32'd0);
      bus.inta_n = 1'b1; tick(2);
      chk("abort_init_ok", 32'(bus.init_ok), 32'd0);
      rd(1'b1, r); chk("abort_imr", 32'(r), 32'h00);
      $display("abort: vec_oe=%0d init_ok=%0d", bus.vec_oe, bus.init_ok);

      // Randomised trials: two acknowledges per trial with NS-EOI in between
      for (int t = 0; t < 24; t++) begin
         bus.irq = 8'h00; tick(2);
         init(8'h13, 8'h01);
         lo  = int'($urandom_range(0, 7));
         imr = 8'($urandom);
         pat = 8'($urandom);
         wr(1'b1, imr);
         wr(1'b0, 8'hC0 | 8'(lo));
         bus.irq = pat; tick(3);
         pend = pat & ~imr;
         id = pick(lo, pend);
         chk($sformatf("rnd%0d_int1", t), 32'(bus.int_out), 32'(id >= 0));
         do_ack(v, oe);
         chk($sformatf("rnd%0d_vec1", t), 32'(v), 32'(8'h40 | 8'((id < 0) ? 7 : id)));
         wr(1'b0, 8'h20);
         if (id >= 0) pend[id] = 1'b0;
         tick(2);
         id2 = pick(lo, pend);
         chk($sformatf("rnd%0d_int2", t), 32'(bus.int_out), 32'(id2 >= 0));
         do_ack(v, oe);
         chk($sformatf("rnd%0d_vec2", t), 32'(v), 32'(8'h40 | 8'((id2 < 0) ? 7 : id2)));
         read_isr(r);
         chk($sformatf("rnd%0d_isr", t), 32'(r), 32'((id2 >= 0) ? (8'h01 << id2) : 8'h00));
         $display("random %0d: lowest=%0d imr=%h irq=%h ids=%0d,%0d isr=%h", t, lo, imr, pat, id, id2, r);
      end

      // Asynchronous reset in the middle of the second INTA pulse
      bus.irq = 8'h00; tick(2);
      init(8'h13, 8'h01); wr(1'b1, 8'h00);
      bus.irq = 8'h08; tick(3);
      bus.inta_n = 1'b0; tick(2);
      bus.inta_n = 1'b1; tick(2);
      bus.inta_n = 1'b0; tick(2);
      chk("rstmid_vec_oe_before", 32'(bus.vec_oe), 32'd1);
      chk("rstmid_vec_before", 32'(bus.vec_out), 32'h43);
      rst = 1'b1;
      #1;
      chk("rstmid_vec_oe", 32'(bus.vec_oe), 32'd0);
      chk("rstmid_vec_out", 32'(bus.vec_out), 32'd0);
      chk("rstmid_int_out", 32'(bus.int_out), 32'd0);
      chk("rstmid_init_ok", 32'(bus.init_ok), 32'd0);
      chk("rstmid_icw3", 32'(bus.icw3), 32'd0);
      rd(1'b1, r); chk("rstmid_imr", 32'(r), 32'hFF);
      $display("reset mid-ack: vec_oe=%0d imr=%h", bus.vec_oe, r);
      bus.inta_n = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
